de0_rst_seq: RTL and testbench

//  Reset/lock sequencer at the opposite end of the PLL rst/locked handshake.

---
 rtl/de0_pkg.sv | 24 ++
 rtl/de0_rst_seq_if.sv | 23 ++
 rtl/de0_sync2.sv | 21 ++
 rtl/de0_rst_seq.sv | 126 ++++++++++++
 tb/tb_de0_rst_seq.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/de0_pkg.sv
// Shared definitions for the DE0 reset/lock sequencer: state encoding and widths.
package de0_pkg;

    localparam logic [1:0] ST_PLLRST   = 2'd0;
    localparam logic [1:0] ST_WAITLOCK = 2'd1;
    localparam logic [1:0] ST_SETTLE   = 2'd2;
    localparam logic [1:0] ST_RUN      = 2'd3;

    localparam int RETRY_W = 8;

    typedef enum logic [1:0] {
        S_PLLRST   = ST_PLLRST,
        S_WAITLOCK = ST_WAITLOCK,
        S_SETTLE   = ST_SETTLE,
        S_RUN      = ST_RUN
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/de0_rst_seq_if.sv
// PLL handshake and system-reset status bundle between the sequencer and its surroundings.
interface de0_rst_seq_if;

    logic                          locked;
    logic                          soft_req;
    logic                          pll_rst;
    logic                          sys_rst_n;
    logic                          ready;
    logic                          lock_loss;
    logic [de0_pkg::RETRY_W-1:0]   retry_cnt;
    logic [1:0]                    state_o;

    modport master (
        input  locked, soft_req,
        output pll_rst, sys_rst_n, ready, lock_loss, retry_cnt, state_o
    );

    modport slave (
        output locked, soft_req,
        input  pll_rst, sys_rst_n, ready, lock_loss, retry_cnt, state_o
    );

endinterface

// File: rtl/de0_sync2.sv
// Two-flop synchroniser for a single asynchronous level, cleared to 0 by rst_n.
module de0_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            q        <= 1'b0;
        end else begin
            meta_reg <= d;
            q        <= meta_reg;
        end
    end

endmodule

// File: rtl/de0_rst_seq.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for a stable lock with retry on
// timeout, then releases the system reset; lock loss or a user request re-enters the sequence.
module de0_rst_seq
    import de0_pkg::*;
#(
    parameter int PLL_RST_CYC  = 16,
    parameter int LOCK_TIMEOUT = 500000,
    parameter int SETTLE_CYC   = 1024
) (
    input  logic            clkin,
    input  logic            rst_n,
    de0_rst_seq_if.master   bus
);

    localparam int CNT_MAX = max3(PLL_RST_CYC, LOCK_TIMEOUT, SETTLE_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    logic               lock_s;
    logic               req_s;
    logic               req_d_reg;
    logic               req_rise;

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   cnt_next;
    logic               timeout;

    logic               pll_rst_reg;
    logic               sys_rst_n_reg;
    logic               ready_reg;
    logic               lock_loss_reg;
    logic [RETRY_W-1:0] retry_reg;

    de0_sync2 u_sync_lock (
        .clk   (clkin),
        .rst_n (rst_n),
        .d     (bus.locked),
        .q     (lock_s)
    );

    de0_sync2 u_sync_req (
        .clk   (clkin),
        .rst_n (rst_n),
        .d     (bus.soft_req),
        .q     (req_s)
    );

    assign req_rise = req_s & ~req_d_reg;
    assign timeout  = (state_reg == S_WAITLOCK) && !lock_s && (cnt_reg == TO_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_PLLRST: begin
                if (cnt_reg == PLL_LAST)
                    state_next = S_WAITLOCK;
            end
            S_WAITLOCK: begin
                if (lock_s)
                    state_next = S_SETTLE;
                else if (timeout)
                    state_next = S_PLLRST;
            end
            S_SETTLE: begin
                // A dropout while settling goes back to waiting without counting a retry.
                if (!lock_s)
                    state_next = S_WAITLOCK;
                else if (cnt_reg == SETTLE_LAST)
                    state_next = S_RUN;
            end
            S_RUN: begin
                // Lock loss takes priority over a coincident user request.
                if (!lock_s)
                    state_next = S_PLLRST;
                else if (req_rise)
                    state_next = S_SETTLE;
            end
            default: state_next = S_PLLRST;
        endcase
    end

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        if (state_next != state_reg)
            cnt_next = '0;
        else if (state_reg == S_RUN)
            cnt_next = cnt_reg;
    end

    // Outputs are decoded from the next state so they move on the same edge as state_reg.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_PLLRST;
            cnt_reg       <= '0;
            req_d_reg     <= 1'b0;
            pll_rst_reg   <= 1'b1;
            sys_rst_n_reg <= 1'b0;
            ready_reg     <= 1'b0;
            lock_loss_reg <= 1'b0;
            retry_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            req_d_reg     <= req_s;
            pll_rst_reg   <= (state_next == S_PLLRST);
            sys_rst_n_reg <= (state_next == S_RUN);
            ready_reg     <= (state_next == S_RUN);
            lock_loss_reg <= (state_reg == S_RUN) && !lock_s;
            if (timeout && (retry_reg != {RETRY_W{1'b1}}))
                retry_reg <= retry_reg + 1'b1;
        end
    end

    assign bus.pll_rst   = pll_rst_reg;
    assign bus.sys_rst_n = sys_rst_n_reg;
    assign bus.ready     = ready_reg;
    assign bus.lock_loss = lock_loss_reg;
    assign bus.retry_cnt = retry_reg;
    assign bus.state_o   = state_reg;

endmodule

// File: tb/tb_de0_rst_seq.sv
// Randomised scenario bench for de0_rst_seq against a cycle-level behavioural model.
module tb_de0_rst_seq;

    localparam int P = 4;
    localparam int T = 20;
    localparam int S = 8;
    localparam logic [13:0] RESET_V = 14'h2000;

    logic clkin = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clkin = ~clkin;

    de0_rst_seq_if bus ();

    de0_rst_seq #(
        .PLL_RST_CYC  (P),
        .LOCK_TIMEOUT (T),
        .SETTLE_CYC   (S)
    ) dut (
        .clkin (clkin),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural model: phase plus time spent in it; inputs seen through a 2-sample delay.
    logic [1:0] m_phase;
    int         m_age;
    int         m_retry;
    logic       m_loss;
    logic       lk1, lk2, rq1, rq2, rq3;

    function automatic logic [1:0] model_next(input logic [1:0] ph, input int age,
                                              input logic ls, input logic rise);
        case (ph)
            2'd0:    return (age + 1 >= P) ? 2'd1 : 2'd0;
            2'd1:    return ls ? 2'd2 : ((age + 1 >= T) ? 2'd0 : 2'd1);
            2'd2:    return !ls ? 2'd1 : ((age + 1 >= S) ? 2'd3 : 2'd2);
            default: return !ls ? 2'd0 : (rise ? 2'd2 : 2'd3);
        endcase
    endfunction

    always @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 2'd0;
            m_age   <= 0;
            m_retry <= 0;
            m_loss  <= 1'b0;
            {lk1, lk2, rq1, rq2, rq3} <= '0;
        end else begin
            m_phase <= model_next(m_phase, m_age, lk2, rq2 && !rq3);
            m_age   <= (model_next(m_phase, m_age, lk2, rq2 && !rq3) != m_phase) ? 0 : m_age + 1;
            m_retry <= (m_phase == 2'd1 && !lk2 && m_age + 1 >= T && m_retry < 255) ? m_retry + 1 : m_retry;
            m_loss  <= (m_phase == 2'd3) && !lk2;
            lk1 <= bus.locked;
            lk2 <= lk1;
            rq1 <= bus.soft_req;
            rq2 <= rq1;
            rq3 <= rq2;
        end
    end

    logic [13:0] dut_v;
    logic [13:0] mod_v;
    assign dut_v = {bus.pll_rst, bus.sys_rst_n, bus.ready, bus.lock_loss, bus.retry_cnt, bus.state_o};
    assign mod_v = {m_phase == 2'd0, m_phase == 2'd3, m_phase == 2'd3, m_loss, m_retry[7:0], m_phase};

    // Holds reset for two cycles and releases it just after a rising edge.
    task automatic do_reset(input logic lk);
        @(negedge clkin);
        rst_n        = 1'b0;
        bus.locked   = lk;
        bus.soft_req = 1'b0;
        repeat (2) @(negedge clkin);
        @(posedge clkin);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clkin);
        rst_n = 1'b0;
        #1;
        total++;
        if (dut_v !== RESET_V) begin
            bad++;
            $display("FAIL reset_values: got=%h required=%h", dut_v, RESET_V);
        end
        $display("test_reset done");
    endtask

    task automatic test_power_up();
        int     pll_hi = 0;
        int     first_ready = -1;
        int     seq[$];
        do_reset(1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clkin);
            total++;
            if (dut_v !== mod_v) begin
                bad++;
                $display("FAIL power_up_cycle%0d: dut=%h model=%h", i, dut_v, mod_v);
            end
            if (bus.pll_rst) pll_hi++;
            if (seq.size() == 0 || seq[$] != int'(bus.state_o)) seq.push_back(int'(bus.state_o));
            if (bus.ready && first_ready < 0) first_ready = i;
        end
        total++;
        if (pll_hi != P) begin
            bad++;
            $display("FAIL power_up_pll_rst_len: got=%0d required=%0d", pll_hi, P);
        end
        total++;
        if (first_ready != P + 1 + S) begin
            bad++;
            $display("FAIL power_up_ready_cycle: got=%0d required=%0d", first_ready, P + 1 + S);
        end
        total++;
        if (seq.size() != 4 || seq[0] != 0 || seq[1] != 1 || seq[2] != 2 || seq[3] != 3) begin
            bad++;
            $display("FAIL power_up_state_seq: got=%p required=0,1,2,3", seq);
        end
        $display("test_power_up done: pll_hi=%0d ready_at=%0d", pll_hi, first_ready);
    endtask

    task automatic test_retry();
        logic [7:0] prev_r = 8'd0;
        logic       prev_p = 1'b1;
        int         last_rise = -1;
        int         run = 0;
        do_reset(1'b0);
        for (int i = 0; i < 6400; i++) begin
            @(negedge clkin);
            total++;
            if (dut_v !== mod_v) begin
                bad++;
                $display("FAIL retry_cycle%0d: dut=%h model=%h", i, dut_v, mod_v);
            end
            if (bus.retry_cnt !== prev_r) begin
                total++;
                if (int'(bus.retry_cnt) != int'(prev_r) + 1) begin
                    bad++;
                    $display("FAIL retry_step: got=%0d required=%0d", bus.retry_cnt, int'(prev_r) + 1);
                end
                prev_r = bus.retry_cnt;
            end
            if (bus.pll_rst && !prev_p) begin
                if (last_rise >= 0) begin
                    total++;
                    if (i - last_rise != P + T) begin
                        bad++;
                        $display("FAIL retry_period: got=%0d required=%0d", i - last_rise, P + T);
                    end
                end
                last_rise = i;
            end
            if (bus.pll_rst) run++;
            else if (prev_p) begin
                total++;
                if (run != P) begin
                    bad++;
                    $display("FAIL retry_pll_rst_len: got=%0d required=%0d", run, P);
                end
                run = 0;
            end
            prev_p = bus.pll_rst;
        end
        total++;
        if (bus.retry_cnt !== 8'd255) begin
            bad++;
            $display("FAIL retry_saturate: got=%0d required=255", bus.retry_cnt);
        end
        $display("test_retry done: retry_cnt=%0d", bus.retry_cnt);
    endtask

    task automatic test_settle_drop();
        int   d = int'($urandom_range(1, 4));
        int   run2 = 0;
        int   final_run = -1;
        logic saw_wl = 1'b0;
        logic ok = 1'b0;
        logic [1:0] prev_s = 2'd0;
        do_reset(1'b1);
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clkin);
            if (bus.state_o == 2'd2) ok = 1'b1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL settle_reach: state=%0d required=2", bus.state_o);
        end
        repeat (5) @(negedge clkin);
        bus.locked = 1'b0;
        prev_s = bus.state_o;
        for (int j = 1; j <= 60; j++) begin
            @(negedge clkin);
            total++;
            if (dut_v !== mod_v) begin
                bad++;
                $display("FAIL settle_drop_cycle%0d: dut=%h model=%h", j, dut_v, mod_v);
            end
            if (j == d) bus.locked = 1'b1;
            if (prev_s == 2'd2 && bus.state_o == 2'd1) saw_wl = 1'b1;
            if (bus.state_o == 2'd2) run2++;
            else begin
                if (prev_s == 2'd2 && bus.state_o == 2'd3) final_run = run2;
                run2 = 0;
            end
            prev_s = bus.state_o;
        end
        total++;
        if (!saw_wl) begin
            bad++;
            $display("FAIL settle_drop_to_waitlock: got=0 required=1");
        end
        total++;
        if (final_run != S) begin
            bad++;
            $display("FAIL settle_full_rerun: got=%0d required=%0d", final_run, S);
        end
        total++;
        if (bus.retry_cnt !== 8'd0 || bus.ready !== 1'b1) begin
            bad++;
            $display("FAIL settle_drop_end: retry=%0d ready=%b required retry=0 ready=1", bus.retry_cnt, bus.ready);
        end
        $display("test_settle_drop done: drop=%0d settle_run=%0d", d, final_run);
    endtask

    task automatic test_lock_loss();
        int   rest = int'($urandom_range(2, 6));
        int   loss_cnt = 0;
        int   loss_at = -1;
        int   pll_hi = 0;
        logic ok = 1'b0;
        do_reset(1'b1);
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clkin);
            if (bus.ready) ok = 1'b1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL lock_loss_reach_run: ready=%b required=1", bus.ready);
        end
        repeat ($urandom_range(1, 5)) @(negedge clkin);
        bus.locked = 1'b0;
        for (int j = 1; j <= 60; j++) begin
            @(negedge clkin);
            total++;
            if (dut_v !== mod_v) begin
                bad++;
                $display("FAIL lock_loss_cycle%0d: dut=%h model=%h", j, dut_v, mod_v);
            end
            if (bus.lock_loss) begin
                loss_cnt++;
                if (loss_at < 0) loss_at = j;
                total++;
                if (bus.sys_rst_n !== 1'b0 || bus.pll_rst !== 1'b1 || bus.ready !== 1'b0) begin
                    bad++;
                    $display("FAIL lock_loss_same_edge: sys_rst_n=%b pll_rst=%b ready=%b required 0,1,0",
                             bus.sys_rst_n, bus.pll_rst, bus.ready);
                end
            end
            if (bus.pll_rst) pll_hi++;
            if (j == rest) bus.locked = 1'b1;
        end
        total++;
        if (loss_cnt != 1 || loss_at != 3) begin
            bad++;
            $display("FAIL lock_loss_pulse: count=%0d at=%0d required count=1 at=3", loss_cnt, loss_at);
        end
        total++;
        if (pll_hi != P || bus.ready !== 1'b1) begin
            bad++;
            $display("FAIL lock_loss_recover: pll_hi=%0d ready=%b required %0d,1", pll_hi, bus.ready, P);
        end
        $display("test_lock_loss done: loss_at=%0d rest=%0d", loss_at, rest);
    endtask

    task automatic test_soft_req();
        int   len = int'($urandom_range(30, 60));
        int   sys_low = 0;
        int   pll_hi = 0;
        int   falls = 0;
        int   settle_entries = 0;
        logic prev_sys = 1'b1;
        logic [1:0] prev_s;
        logic ok = 1'b0;
        do_reset(1'b1);
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clkin);
            if (bus.ready) ok = 1'b1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL soft_req_reach_run: ready=%b required=1", bus.ready);
        end
        bus.soft_req = 1'b1;
        for (int j = 1; j <= len + 40; j++) begin
            @(negedge clkin);
            total++;
            if (dut_v !== mod_v) begin
                bad++;
                $display("FAIL soft_req_cycle%0d: dut=%h model=%h", j, dut_v, mod_v);
            end
            if (!bus.sys_rst_n) sys_low++;
            if (bus.pll_rst) pll_hi++;
            if (prev_sys && !bus.sys_rst_n) falls++;
            prev_sys = bus.sys_rst_n;
            if (j == len) bus.soft_req = 1'b0;
        end
        total++;
        if (sys_low != S || pll_hi != 0 || falls != 1) begin
            bad++;
            $display("FAIL soft_req_run: sys_low=%0d pll_hi=%0d falls=%0d required %0d,0,1",
                     sys_low, pll_hi, falls, S);
        end
        // Same pulse while waiting for lock must be ignored.
        do_reset(1'b0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clkin);
            if (bus.state_o == 2'd1) ok = 1'b1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL soft_req_reach_waitlock: state=%0d required=1", bus.state_o);
        end
        bus.soft_req = 1'b1;
        prev_s = bus.state_o;
        for (int j = 1; j <= 60; j++) begin
            @(negedge clkin);
            total++;
            if (dut_v !== mod_v) begin
                bad++;
                $display("FAIL soft_req_wl_cycle%0d: dut=%h model=%h", j, dut_v, mod_v);
            end
            if (prev_s != 2'd2 && bus.state_o == 2'd2) settle_entries++;
            prev_s = bus.state_o;
            if (j == 8) bus.soft_req = 1'b0;
            if (j == 12) bus.locked = 1'b1;
        end
        total++;
        if (settle_entries != 1 || bus.ready !== 1'b1) begin
            bad++;
            $display("FAIL soft_req_waitlock_ignored: settle_entries=%0d ready=%b required 1,1",
                     settle_entries, bus.ready);
        end
        $display("test_soft_req done: len=%0d sys_low=%0d", len, sys_low);
    endtask

    task automatic test_async_reset();
        for (int mode = 0; mode < 2; mode++) begin
            logic [1:0] target = (mode == 0) ? 2'd2 : 2'd3;
            logic       ok = 1'b0;
            do_reset(1'b0);
            for (int i = 0; i < 60; i++) begin
                @(negedge clkin);
                total++;
                if (dut_v !== mod_v) begin
                    bad++;
                    $display("FAIL async_pre_cycle%0d: dut=%h model=%h", i, dut_v, mod_v);
                end
            end
            bus.locked = 1'b1;
            for (int i = 0; i < 40 && !ok; i++) begin
                @(negedge clkin);
                if (bus.state_o == target) ok = 1'b1;
            end
            total++;
            if (!ok || bus.retry_cnt == 8'd0) begin
                bad++;
                $display("FAIL async_reach: state=%0d retry=%0d required state=%0d retry>0",
                         bus.state_o, bus.retry_cnt, target);
            end
            repeat ($urandom_range(1, 5)) @(negedge clkin);
            #2 rst_n = 1'b0;
            #1;
            total++;
            if (dut_v !== RESET_V) begin
                bad++;
                $display("FAIL async_reset_mode%0d: got=%h required=%h", mode, dut_v, RESET_V);
            end
        end
        $display("test_async_reset done");
    endtask

    initial begin
        bus.locked   = 1'b0;
        bus.soft_req = 1'b0;
        test_reset();
        test_power_up();
        test_retry();
        test_settle_drop();
        test_lock_loss();
        test_soft_req();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
